anton_neopixel_decoder: RTL and testbench
=========================================

Name: anton_neopixel_decoder

Overview:
- Receive-side counterpart of the NeoPixel stream encoder.
- Samples a single-wire WS2812-style NRZ waveform, measures each high pulse to recover bits, and assembles them MSB-first into bytes.
- Writes each byte with a strobe and buffer index, and detects the latch gap as end-of-frame.
- Used for controller loopback self-test and for sniffing a daisy-chained strip.

Parameters:
- BUFFER_END, `BUFFER_END_DEFAULT, last valid byte index in a frame (common header value).
- BUFFER_BITS, `CLOG2(BUFFER_END+1), localparam, width of the byte index.
- THRESHOLD_CYCLES, 4, high-pulse length in clocks at or above which the bit is 1.
- MAX_HIGH_CYCLES, 7, high-pulse length in clocks above which the pulse is a glitch.
- RESET_CYCLES, 350, continuous low length in clocks that marks latch/end-of-frame (50 us at 7 MHz).

Ports:
- clk7mhz, input, 1, sole clock.
- rst, input, 1, asynchronous active-high reset.
- neoData, input, 1, raw serial line, asynchronous to clk7mhz.
- regCtrlRun, input, 1, decoder enable.
- errClear, input, 1, synchronous clear of sticky error flags.
- pixelByte, output, 8, last completed byte, first received bit in [7].
- pixelByteValid, output, 1, one-cycle strobe qualifying pixelByte/pixelByteIndex.
- pixelByteIndex, output, BUFFER_BITS, index of the byte being strobed.
- frameDone, output, 1, one-cycle strobe on latch detection.
- errGlitch, output, 1, sticky: high pulse exceeded MAX_HIGH_CYCLES.
- errOverflow, output, 1, sticky: byte received after index BUFFER_END.
- errPartial, output, 1, sticky: latch arrived with 1-7 bits pending.

Behaviour:
- Reset (async, rst=1): all outputs 0; state WAIT_RESET; all counters, shift register and sync flops 0.
- Input synchronisation: neoData passes through 2 flops (s2). prev holds s2 from the previous cycle. A rise is s2=1 & prev=0; a fall is s2=0 & prev=1.
- regCtrlRun=0: state is forced to WAIT_RESET; bit and byte counters cleared; strobes held 0. Sticky errors are unchanged.
- State WAIT_RESET: lowCnt counts cycles with s2=0 and resets to 0 when s2=1. At lowCnt==RESET_CYCLES, go to IDLE with no frameDone. Data arriving mid-frame after reset or enable is therefore ignored until a full latch gap.
- State IDLE: on rise, go to HIGH with highCnt=1.
- State HIGH: highCnt increments each cycle s2=1.
  - If highCnt would exceed MAX_HIGH_CYCLES: set errGlitch, clear bitCnt, go to WAIT_RESET.
  - On fall: bit = (highCnt >= THRESHOLD_CYCLES); shift = {shift[6:0], bit}; bitCnt++; lowCnt=1; go to LOW.
- Byte completion: when bitCnt reaches 8, on the same clock:
  - pixelByte <= new shift value; pixelByteIndex <= byteCnt; pixelByteValid=1 for one cycle; bitCnt <= 0.
  - byteCnt increments, saturating at BUFFER_END+1.
  - If byteCnt already equals BUFFER_END+1: no strobe, pixelByte unchanged, set errOverflow.
- State LOW:
  - On rise: go to HIGH with highCnt=1.
  - Else lowCnt increments. At lowCnt==RESET_CYCLES: frameDone=1 for one cycle; byteCnt <= 0; if bitCnt!=0, set errPartial and clear bitCnt; go to IDLE.
- Latency: pixelByteValid rises on the 3rd clk7mhz rising edge after neoData falls at the end of the 8th bit. frameDone follows the last fall by RESET_CYCLES+2 edges.
- Counter widths: highCnt is sized to hold MAX_HIGH_CYCLES+1; lowCnt is sized to hold RESET_CYCLES.
- Sticky flags clear on errClear=1 (synchronous). When set and clear coincide, set wins.
- A one-cycle high pulse decodes as bit 0; no minimum-width filtering.
- pixelByte holds its value between strobes.

Test Plan:
- Reset and arm: rst pulse, then hold line low 349 cycles, then send a bit → nothing decoded. Repeat with 350 low cycles first → accepted (IDLE reached).
- Single byte: encoder timing (0 = 2 high/6 low, 1 = 5 high/3 low), byte 0xA5, then 400 low cycles → one pixelByteValid with pixelByte=0xA5, index 0, strobed 3 edges after the last fall; frameDone once; no errors.
- Full frame with BUFFER_END=3: bytes 0x00, 0xFF, 0x3C, 0x81 then latch → indices 0-3 in order. A 5th byte 0x55 → no strobe, errOverflow=1. Next frame restarts at index 0.
- Glitch: 9-cycle high pulse mid-byte → errGlitch=1, no strobe. Decoding resumes only after 350 low cycles. errClear → errGlitch=0.
- Partial byte: 5 bits then latch → frameDone=1, errPartial=1, no pixelByteValid.
- Disable and async reset mid-byte: regCtrlRun=0 after 4 bits, then re-enable → partial bits discarded, re-arm required. Repeat with rst asserted mid-pulse → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/anton_neopixel_decoder.sv
// WS2812-style NRZ receiver: times each high pulse to get a bit, packs bytes
// MSB-first, strobes byte+index, flags latch gaps, glitches, overflow, partials.
//
// Ports:
//   clk7mhz        sole clock
//   rst            asynchronous active-high reset
//   neoData        raw serial line (asynchronous, synchronised here)
//   regCtrlRun     decoder enable
//   errClear       synchronous clear of the sticky error flags
//   pixelByte      last completed byte, first received bit in [7]
//   pixelByteValid one-cycle strobe for pixelByte / pixelByteIndex
//   pixelByteIndex index of the byte being strobed
//   frameDone      one-cycle strobe on latch detection
//   errGlitch      sticky: high pulse longer than MAX_HIGH_CYCLES
//   errOverflow    sticky: byte received after index BUFFER_END
//   errPartial     sticky: latch arrived with 1-7 bits pending

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 63
`endif

module anton_neopixel_decoder #(
  parameter int BUFFER_END = `BUFFER_END_DEFAULT,
  parameter int THRESHOLD_CYCLES = 4,
  parameter int MAX_HIGH_CYCLES = 7,
  parameter int RESET_CYCLES = 350,
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   rst,
  input  logic                   neoData,
  input  logic                   regCtrlRun,
  input  logic                   errClear,
  output logic [7:0]             pixelByte,
  output logic                   pixelByteValid,
  output logic [BUFFER_BITS-1:0] pixelByteIndex,
  output logic                   frameDone,
  output logic                   errGlitch,
  output logic                   errOverflow,
  output logic                   errPartial
);

  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam int HW = $clog2(MAX_HIGH_CYCLES + 2);
  // byteCnt must also hold the saturated value BUFFER_END+1
  localparam int CW = $clog2(BUFFER_END + 2);

  typedef enum logic [1:0] {
    WAIT_RESET,
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t state, stateNext;

  logic sync1, s2, prev;
  logic rise, fall;

  logic [LW-1:0] lowCnt, lowNext, lowInc;
  logic [HW-1:0] highCnt, highNext, highInc;
  logic [2:0]    bitCnt, bitNext;
  logic [CW-1:0] byteCnt, byteNext;
  logic [7:0]    shift, shiftNext;
  logic [7:0]    byteNextVal;
  logic [BUFFER_BITS-1:0] idxNext;
  logic validNext, frameNext;
  logic setGlitch, setOvf, setPart;
  logic bitVal;

  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;
  assign lowInc = lowCnt + 1'b1;
  assign highInc = highCnt + 1'b1;
  assign bitVal = (highCnt >= HW'(THRESHOLD_CYCLES));

  always_comb begin
    stateNext = state;
    lowNext = lowCnt;
    highNext = highCnt;
    bitNext = bitCnt;
    byteNext = byteCnt;
    shiftNext = shift;
    byteNextVal = pixelByte;
    idxNext = pixelByteIndex;
    validNext = 1'b0;
    frameNext = 1'b0;
    setGlitch = 1'b0;
    setOvf = 1'b0;
    setPart = 1'b0;
    if (!regCtrlRun) begin
      stateNext = WAIT_RESET;
      lowNext = '0;
      bitNext = '0;
      byteNext = '0;
    end else begin
      unique case (state)
        WAIT_RESET: begin
          // Only a full latch gap arms the decoder, so a
          // mid-frame start never yields misaligned bytes.
          if (s2) begin
            lowNext = '0;
          end else begin
            lowNext = lowInc;
            if (lowInc == LW'(RESET_CYCLES))
              stateNext = IDLE;
          end
        end
        IDLE: begin
          if (rise) begin
            highNext = HW'(1);
            stateNext = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            shiftNext = {shift[6:0], bitVal};
            lowNext = LW'(1);
            stateNext = LOW;
            if (bitCnt == 3'd7) begin
              bitNext = '0;
              if (byteCnt == CW'(BUFFER_END + 1)) begin
                setOvf = 1'b1;
              end else begin
                byteNextVal = {shift[6:0], bitVal};
                idxNext = byteCnt[BUFFER_BITS-1:0];
                validNext = 1'b1;
                byteNext = byteCnt + 1'b1;
              end
            end else begin
              bitNext = bitCnt + 1'b1;
            end
          end else if (s2) begin
            if (highInc > HW'(MAX_HIGH_CYCLES)) begin
              setGlitch = 1'b1;
              bitNext = '0;
              lowNext = '0;
              stateNext = WAIT_RESET;
            end else begin
              highNext = highInc;
            end
          end
        end
        LOW: begin
          if (rise) begin
            highNext = HW'(1);
            stateNext = HIGH;
          end else begin
            lowNext = lowInc;
            if (lowInc == LW'(RESET_CYCLES)) begin
              frameNext = 1'b1;
              byteNext = '0;
              if (bitCnt != 3'd0) begin
                setPart = 1'b1;
                bitNext = '0;
              end
              stateNext = IDLE;
            end
          end
        end
        default: stateNext = WAIT_RESET;
      endcase
    end
  end

  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
      state <= WAIT_RESET;
      lowCnt <= '0;
      highCnt <= '0;
      bitCnt <= '0;
      byteCnt <= '0;
      shift <= '0;
      pixelByte <= '0;
      pixelByteIndex <= '0;
      pixelByteValid <= 1'b0;
      frameDone <= 1'b0;
      errGlitch <= 1'b0;
      errOverflow <= 1'b0;
      errPartial <= 1'b0;
    end else begin
      sync1 <= neoData;
      s2 <= sync1;
      prev <= s2;
      state <= stateNext;
      lowCnt <= lowNext;
      highCnt <= highNext;
      bitCnt <= bitNext;
      byteCnt <= byteNext;
      shift <= shiftNext;
      pixelByte <= byteNextVal;
      pixelByteIndex <= idxNext;
      pixelByteValid <= validNext;
      frameDone <= frameNext;
      // set wins over a coincident clear
      errGlitch <= setGlitch | (errGlitch & ~errClear);
      errOverflow <= setOvf | (errOverflow & ~errClear);
      errPartial <= setPart | (errPartial & ~errClear);
    end
  end

endmodule

// File: tb/tb_anton_neopixel_decoder.sv
// Directed bench for anton_neopixel_decoder with BUFFER_END=3.
// A negedge monitor logs strobes; all checks go through chk.

module tb_anton_neopixel_decoder;

  localparam int BE = 3;
  localparam int BB = $clog2(BE + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic neo = 1'b0;
  logic run = 1'b1;
  logic errClr = 1'b0;
  logic [7:0] pByte;
  logic pValid;
  logic [BB-1:0] pIdx;
  logic fDone;
  logic eGlitch, eOvf, ePart;

  anton_neopixel_decoder #(.BUFFER_END(BE)) dut (
    .clk7mhz(clk),
    .rst(rst),
    .neoData(neo),
    .regCtrlRun(run),
    .errClear(errClr),
    .pixelByte(pByte),
    .pixelByteValid(pValid),
    .pixelByteIndex(pIdx),
    .frameDone(fDone),
    .errGlitch(eGlitch),
    .errOverflow(eOvf),
    .errPartial(ePart)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fallCyc = 0;
  int nByte = 0;
  int nFrame = 0;
  int lastByteCyc = 0;
  int lastFrameCyc = 0;
  logic [7:0] byteLog [0:63];
  logic [BB-1:0] idxLog [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pValid) begin
      byteLog[nByte[5:0]] <= pByte;
      idxLog[nByte[5:0]] <= pIdx;
      nByte <= nByte + 1;
      lastByteCyc <= cyc;
    end
    if (fDone) begin
      nFrame <= nFrame + 1;
      lastFrameCyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic hi(input int n);
    neo = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic lo(input int n);
    neo = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBit(input logic b);
    neo = 1'b1;
    repeat (b ? 5 : 2) @(negedge clk);
    neo = 1'b0;
    fallCyc = cyc;
    repeat (b ? 3 : 6) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) sendBit(v[i]);
  endtask

  task automatic clearErr;
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] outVec();
    return {19'd0, pByte, pValid, pIdx, fDone, eGlitch, eOvf, ePart};
  endfunction

  int nb0, nf0, bf;

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("resetOutputs", outVec(), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 349 low cycles: not armed, byte ignored
    hi(3);
    lo(349);
    sendByte(8'hA5);
    lo(400);
    chk("arm349Bytes", nByte, 0);
    chk("arm349Frames", nFrame, 0);

    // re-enter WAIT_RESET, then 350 low cycles arms
    run = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b1;
    hi(3);
    lo(350);
    sendByte(8'hA5);
    bf = fallCyc;
    lo(400);
    chk("singleCount", nByte, 1);
    chk("singleByte", byteLog[0], 8'hA5);
    chk("singleIdx", idxLog[0], 0);
    chk("singleLatency", lastByteCyc - bf, 3);
    chk("singleFrames", nFrame, 1);
    chk("frameLatency", lastFrameCyc - bf, 352);
    chk("singleErrs", {eGlitch, eOvf, ePart}, 0);

    // full frame plus overflow byte
    sendByte(8'h00);
    sendByte(8'hFF);
    sendByte(8'h3C);
    sendByte(8'h81);
    sendByte(8'h55);
    lo(400);
    chk("fullCount", nByte, 5);
    chk("full0", {idxLog[1], byteLog[1]}, {2'd0, 8'h00});
    chk("full1", {idxLog[2], byteLog[2]}, {2'd1, 8'hFF});
    chk("full2", {idxLog[3], byteLog[3]}, {2'd2, 8'h3C});
    chk("full3", {idxLog[4], byteLog[4]}, {2'd3, 8'h81});
    chk("ovfFlag", eOvf, 1);
    chk("ovfHold", pByte, 8'h81);
    chk("fullFrames", nFrame, 2);
    sendByte(8'h12);
    lo(400);
    chk("restartIdx", {idxLog[5], byteLog[5]}, {2'd0, 8'h12});
    clearErr();
    chk("ovfClear", eOvf, 0);

    // glitch mid-byte, following byte ignored until re-arm
    nb0 = nByte;
    nf0 = nFrame;
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    hi(9);
    lo(20);
    sendByte(8'h33);
    lo(400);
    chk("glitchFlag", eGlitch, 1);
    chk("glitchNoByte", nByte - nb0, 0);
    chk("glitchNoFrame", nFrame - nf0, 0);
    sendByte(8'h5A);
    lo(400);
    chk("glitchResume", {idxLog[nb0], byteLog[nb0]}, {2'd0, 8'h5A});
    clearErr();
    chk("glitchClear", eGlitch, 0);

    // partial byte then latch
    nb0 = nByte;
    nf0 = nFrame;
    for (int i = 0; i < 5; i++) sendBit(i[0]);
    lo(400);
    chk("partialFrame", nFrame - nf0, 1);
    chk("partialFlag", ePart, 1);
    chk("partialNoByte", nByte - nb0, 0);

    // disable mid-byte discards bits and needs re-arm
    nb0 = nByte;
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    run = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b1;
    sendByte(8'h99);
    lo(400);
    chk("disableNoByte", nByte - nb0, 0);
    sendByte(8'hC3);
    lo(400);
    chk("disableResume", {idxLog[nb0], byteLog[nb0]}, {2'd0, 8'hC3});
    chk("partialSticky", ePart, 1);

    // async reset mid-pulse
    sendBit(1'b1);
    neo = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("asyncReset", outVec(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nb0 = nByte;
    lo(400);
    sendByte(8'h7E);
    lo(400);
    chk("postResetByte", {idxLog[nb0], byteLog[nb0]}, {2'd0, 8'h7E});
    chk("postResetErrs", {eGlitch, eOvf, ePart}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
